// File: rtl/ahb_req_master.sv
// ahb_req_master: queued AHB-Lite master. Requests are buffered in a FIFO
// and issued as single NONSEQ transfers with pipelined address/data phases.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               request port (valid/ready), write/size/addr/wdata
//   rsp_*               one-cycle response pulse with write flag, rdata, err
//   scsu_m_ahb_mh*      registered AHB master outputs
//   ahb_scsu_m_sh*      AHB slave return signals (rdata, ready, resp)
module ahb_req_master #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [13:1] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  scsu_m_ahb_mhtrans,
  output logic [1:0]  scsu_m_ahb_mhsize,
  output logic        scsu_m_ahb_mhwrite,
  output logic [13:1] scsu_m_ahb_mhaddr,
  output logic [15:0] scsu_m_ahb_mhwdata,
  input  logic [15:0] ahb_scsu_m_shrdata,
  input  logic        ahb_scsu_m_shready,
  input  logic [1:0]  ahb_scsu_m_shresp
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HR_ERROR  = 2'b01;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [13:1] addr;
    logic [15:0] wdata;
  } req_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_DATA,
    DATA,
    ERR_CANCEL
  } state_t;

  state_t state, state_n;

  req_t          fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] nx_ptr;
  logic [PW-1:0] hd_idx;
  logic [CW-1:0] cnt;

  logic push;
  logic pop;
  logic ld_addr;
  logic dp_ld;
  logic dp_done;
  logic any;
  logic more;
  logic hready;
  logic herr;
  logic dp_write;

  assign hready    = ahb_scsu_m_shready;
  assign herr      = (ahb_scsu_m_shresp == HR_ERROR);
  assign req_ready = (cnt != CW'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign any       = (cnt != '0);
  // Entries left once the current head has been popped.
  assign more      = (cnt > CW'(1));
  assign nx_ptr    = rd_ptr + PW'(1);
  // The address loaded at an acceptance edge is the post-pop head.
  assign hd_idx    = pop ? nx_ptr : rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= nx_ptr;
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= {req_write, req_size, req_addr, req_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    ld_addr = 1'b0;
    dp_ld   = 1'b0;
    dp_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (hready && any) begin
          ld_addr = 1'b1;
          state_n = ADDR;
        end
      end
      ADDR, ADDR_DATA: begin
        if (hready) begin
          dp_done = (state == ADDR_DATA);
          pop     = 1'b1;
          dp_ld   = 1'b1;
          ld_addr = more;
          state_n = more ? ADDR_DATA : DATA;
        end else if (state == ADDR_DATA && herr) begin
          // First ERROR cycle: drop the pending address, keep its entry.
          state_n = ERR_CANCEL;
        end
      end
      DATA, ERR_CANCEL: begin
        if (hready) begin
          dp_done = 1'b1;
          ld_addr = any;
          state_n = any ? ADDR : IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scsu_m_ahb_mhtrans <= HT_IDLE;
      scsu_m_ahb_mhsize  <= '0;
      scsu_m_ahb_mhwrite <= 1'b0;
      scsu_m_ahb_mhaddr  <= '0;
      scsu_m_ahb_mhwdata <= '0;
      dp_write           <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_write          <= 1'b0;
      rsp_rdata          <= '0;
      rsp_err            <= 1'b0;
    end else begin
      if (state_n == ADDR || state_n == ADDR_DATA) begin
        scsu_m_ahb_mhtrans <= HT_NONSEQ;
      end else begin
        scsu_m_ahb_mhtrans <= HT_IDLE;
      end
      if (ld_addr) begin
        scsu_m_ahb_mhsize  <= fifo[hd_idx].size;
        scsu_m_ahb_mhwrite <= fifo[hd_idx].write;
        scsu_m_ahb_mhaddr  <= fifo[hd_idx].addr;
      end
      if (dp_ld) begin
        dp_write <= fifo[rd_ptr].write;
        if (fifo[rd_ptr].write) begin
          scsu_m_ahb_mhwdata <= fifo[rd_ptr].wdata;
        end else begin
          scsu_m_ahb_mhwdata <= '0;
        end
      end
      rsp_valid <= dp_done;
      if (dp_done) begin
        rsp_write <= dp_write;
        rsp_rdata <= dp_write ? '0 : ahb_scsu_m_shrdata;
        rsp_err   <= herr;
      end
    end
  end

endmodule

// File: tb/tb_ahb_req_master.sv
// tb_ahb_req_master: directed bench for ahb_req_master with a simple
// memory-backed AHB slave whose ready/resp are driven by the scenarios.
module tb_ahb_req_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [13:1] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_write;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  mhtrans;
  logic [1:0]  mhsize;
  logic        mhwrite;
  logic [13:1] mhaddr;
  logic [15:0] mhwdata;
  logic [15:0] shrdata;
  logic        shready = 1'b1;
  logic [1:0]  shresp = 2'b00;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_req_master #(.FIFO_DEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_write          (req_write),
    .req_size           (req_size),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_write          (rsp_write),
    .rsp_rdata          (rsp_rdata),
    .rsp_err            (rsp_err),
    .scsu_m_ahb_mhtrans (mhtrans),
    .scsu_m_ahb_mhsize  (mhsize),
    .scsu_m_ahb_mhwrite (mhwrite),
    .scsu_m_ahb_mhaddr  (mhaddr),
    .scsu_m_ahb_mhwdata (mhwdata),
    .ahb_scsu_m_shrdata (shrdata),
    .ahb_scsu_m_shready (shready),
    .ahb_scsu_m_shresp  (shresp)
  );

  logic [15:0] smem [8192];
  logic        s_act = 1'b0;
  logic        s_wr = 1'b0;
  logic [12:0] s_addr = '0;
  logic        pl_en = 1'b0;
  logic [12:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  logic [13:0] acc_log [256];
  int          acc_n = 0;
  logic [16:0] rsp_log [256];
  int          rsp_n = 0;

  logic [15:0] wd [3] = '{16'h1234, 16'hA0A0, 16'h0A0A};

  assign shrdata = (s_act && !s_wr) ? smem[s_addr] : 16'h0000;

  always @(posedge clk) begin
    if (pl_en) begin
      smem[pl_addr] <= pl_data;
    end
    if (rst) begin
      s_act <= 1'b0;
    end else if (shready) begin
      if (s_act && s_wr) begin
        smem[s_addr] <= mhwdata;
      end
      if (mhtrans == 2'b10) begin
        s_act <= 1'b1;
        s_wr <= mhwrite;
        s_addr <= mhaddr;
        acc_log[acc_n] <= {mhwrite, mhaddr};
        acc_n <= acc_n + 1;
      end else begin
        s_act <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rsp_valid) begin
      rsp_log[rsp_n] <= {rsp_err, rsp_rdata};
      rsp_n <= rsp_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [12:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic set_req(input logic w, input logic [12:0] a,
                         input logic [15:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_size = 2'b01;
    req_addr = a;
    req_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    shready = 1'b1;
    shresp = 2'b00;
    repeat (3) tick();
    checks++;
    if ({mhtrans, mhsize, mhwrite, mhaddr, mhwdata} !== 34'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0",
               {mhtrans, mhsize, mhwrite, mhaddr, mhwdata});
    end
    checks++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== 19'h0) begin
      failures++;
      $display("FAIL reset_rsp got=%h exp=0",
               {rsp_valid, rsp_write, rsp_err, rsp_rdata});
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", req_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    set_req(1'b1, 13'h0000, 16'h1234);
    tick();
    req_valid = 1'b0;
    checks++;
    if (mhtrans !== 2'b00) begin
      failures++;
      $display("FAIL sw_idle_at_push got=%b exp=00", mhtrans);
    end
    tick();
    checks++;
    if ({mhtrans, mhwrite, mhaddr, mhsize} !== {2'b10, 1'b1, 13'h0, 2'b01})
    begin
      failures++;
      $display("FAIL sw_addr_phase got=%h exp=%h",
               {mhtrans, mhwrite, mhaddr, mhsize},
               {2'b10, 1'b1, 13'h0, 2'b01});
    end
    tick();
    checks++;
    if ({mhtrans, mhwdata, rsp_valid} !== {2'b00, 16'h1234, 1'b0}) begin
      failures++;
      $display("FAIL sw_data_phase got=%h exp=%h",
               {mhtrans, mhwdata, rsp_valid}, {2'b00, 16'h1234, 1'b0});
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !==
        {1'b1, 1'b1, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL sw_rsp got=%h exp=%h",
               {rsp_valid, rsp_write, rsp_err, rsp_rdata},
               {1'b1, 1'b1, 1'b0, 16'h0});
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL sw_rsp_pulse got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_burst();
    int rb;
    int ab;
    int ns;
    int run;
    int maxrun;
    logic [16:0] er;
    logic [13:0] ea;
    rb = rsp_n;
    ab = acc_n;
    ns = 0;
    run = 0;
    maxrun = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 6) begin
        set_req(i < 3, 13'(i % 3), wd[i % 3]);
        checks++;
        if (req_ready !== 1'b1) begin
          failures++;
          $display("FAIL burst_ready i=%0d got=%b exp=1", i, req_ready);
        end
      end else begin
        req_valid = 1'b0;
      end
      tick();
      if (mhtrans == 2'b10) begin
        ns++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    checks++;
    if (ns != 6 || maxrun != 6) begin
      failures++;
      $display("FAIL burst_nonseq got=%0d/%0d exp=6/6", ns, maxrun);
    end
    checks++;
    if (rsp_n - rb != 6 || acc_n - ab != 6) begin
      failures++;
      $display("FAIL burst_count got=%0d/%0d exp=6/6", rsp_n - rb, acc_n - ab);
    end else begin
      for (int i = 0; i < 6; i++) begin
        er = (i < 3) ? 17'h0 : {1'b0, wd[i - 3]};
        ea = {(i < 3) ? 1'b1 : 1'b0, 13'(i % 3)};
        checks++;
        if (rsp_log[rb + i] !== er || acc_log[ab + i] !== ea) begin
          failures++;
          $display("FAIL burst_order i=%0d got=%h/%h exp=%h/%h", i,
                   rsp_log[rb + i], acc_log[ab + i], er, ea);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    int rb;
    preload(13'h1006, 16'hBEEF);
    rb = rsp_n;
    set_req(1'b0, 13'h1006, 16'hFFFF);
    tick();
    req_valid = 1'b0;
    tick();
    shready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mhtrans, mhaddr, mhwrite, rsp_valid} !==
          {2'b10, 13'h1006, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL wait_addr_hold i=%0d got=%h exp=%h", i,
                 {mhtrans, mhaddr, mhwrite, rsp_valid},
                 {2'b10, 13'h1006, 1'b0, 1'b0});
      end
      if (i < 2) tick();
    end
    shready = 1'b1;
    tick();
    shready = 1'b0;
    tick();
    checks++;
    if ({mhtrans, rsp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL wait_data_hold got=%b exp=000", {mhtrans, rsp_valid});
    end
    shready = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !==
        {1'b1, 1'b0, 1'b0, 16'hBEEF}) begin
      failures++;
      $display("FAIL wait_rdata got=%h exp=%h",
               {rsp_valid, rsp_write, rsp_err, rsp_rdata},
               {1'b1, 1'b0, 1'b0, 16'hBEEF});
    end
    tick();
    checks++;
    if (rsp_n - rb != 1) begin
      failures++;
      $display("FAIL wait_rsp_count got=%0d exp=1", rsp_n - rb);
    end
  endtask

  task automatic test_error_cancel();
    int rb;
    int ab;
    rb = rsp_n;
    ab = acc_n;
    set_req(1'b1, 13'h1808, 16'h5555);
    tick();
    set_req(1'b1, 13'h1809, 16'h6666);
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if ({mhtrans, mhaddr, mhwdata} !== {2'b10, 13'h1809, 16'h5555}) begin
      failures++;
      $display("FAIL err_overlap got=%h exp=%h", {mhtrans, mhaddr, mhwdata},
               {2'b10, 13'h1809, 16'h5555});
    end
    shready = 1'b0;
    shresp = 2'b01;
    tick();
    checks++;
    if ({mhtrans, rsp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL err_cancel got=%b exp=000", {mhtrans, rsp_valid});
    end
    shready = 1'b1;
    tick();
    shresp = 2'b00;
    checks++;
    if ({rsp_valid, rsp_write, rsp_err} !== 3'b111) begin
      failures++;
      $display("FAIL err_rsp got=%b exp=111", {rsp_valid, rsp_write, rsp_err});
    end
    checks++;
    if ({mhtrans, mhaddr} !== {2'b10, 13'h1809}) begin
      failures++;
      $display("FAIL err_reissue got=%h exp=%h", {mhtrans, mhaddr},
               {2'b10, 13'h1809});
    end
    for (int i = 0; i < 10 && rsp_n - rb < 2; i++) tick();
    checks++;
    if (rsp_n - rb != 2 || acc_n - ab != 2) begin
      failures++;
      $display("FAIL err_count got=%0d/%0d exp=2/2", rsp_n - rb, acc_n - ab);
    end else begin
      checks++;
      if ({rsp_log[rb][16], rsp_log[rb + 1][16], acc_log[ab][12:0],
           acc_log[ab + 1][12:0]} !== {1'b1, 1'b0, 13'h1808, 13'h1809}) begin
        failures++;
        $display("FAIL err_order got=%b%b %h %h exp=10 1808 1809",
                 rsp_log[rb][16], rsp_log[rb + 1][16],
                 acc_log[ab][12:0], acc_log[ab + 1][12:0]);
      end
    end
  endtask

  task automatic test_full_fifo();
    int rb;
    int n;
    logic ok;
    for (int i = 0; i < 5; i++) preload(13'h10 + 13'(i), 16'hC000 + 16'(i));
    rb = rsp_n;
    shready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b0, 13'h10 + 13'(i), 16'h0);
      checks++;
      if (req_ready !== 1'b1) begin
        failures++;
        $display("FAIL full_ready_early i=%0d got=%b exp=1", i, req_ready);
      end
      tick();
    end
    set_req(1'b0, 13'h14, 16'h0);
    checks++;
    if ({req_ready, mhtrans} !== 3'b000) begin
      failures++;
      $display("FAIL full_ready_low got=%b exp=000", {req_ready, mhtrans});
    end
    shready = 1'b1;
    n = 0;
    do begin
      ok = req_ready;
      tick();
      n++;
    end while (!ok && n < 20);
    req_valid = 1'b0;
    checks++;
    if (!ok || n != 3) begin
      failures++;
      $display("FAIL full_fifth_push got=%b/%0d exp=1/3", ok, n);
    end
    for (int i = 0; i < 30 && rsp_n - rb < 5; i++) tick();
    checks++;
    if (rsp_n - rb != 5) begin
      failures++;
      $display("FAIL full_count got=%0d exp=5", rsp_n - rb);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rsp_log[rb + i] !== {1'b0, 16'hC000 + 16'(i)}) begin
          failures++;
          $display("FAIL full_order i=%0d got=%h exp=%h", i,
                   rsp_log[rb + i], {1'b0, 16'hC000 + 16'(i)});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int rb;
    logic busy;
    rb = rsp_n;
    set_req(1'b1, 13'h0020, 16'h7777);
    tick();
    set_req(1'b0, 13'h0021, 16'h0);
    tick();
    set_req(1'b0, 13'h0022, 16'h0);
    tick();
    req_valid = 1'b0;
    checks++;
    if ({mhtrans, mhaddr, mhwdata} !== {2'b10, 13'h0021, 16'h7777}) begin
      failures++;
      $display("FAIL rstmid_pre got=%h exp=%h", {mhtrans, mhaddr, mhwdata},
               {2'b10, 13'h0021, 16'h7777});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({mhtrans, mhsize, mhwrite, mhaddr, mhwdata, rsp_valid, rsp_write,
         rsp_err, rsp_rdata, req_ready} !== 54'h1) begin
      failures++;
      $display("FAIL rstmid_vals got=%h exp=1",
               {mhtrans, mhsize, mhwrite, mhaddr, mhwdata, rsp_valid,
                rsp_write, rsp_err, rsp_rdata, req_ready});
    end
    busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mhtrans != 2'b00 || rsp_valid) busy = 1'b1;
    end
    checks++;
    if (busy || rsp_n != rb) begin
      failures++;
      $display("FAIL rstmid_quiet got=%b/%0d exp=0/0", busy, rsp_n - rb);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_wait_states();
    test_error_cancel();
    test_full_fifo();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
